pipelined_prenormalizer: RTL

PIPELINED_PRENORMALIZER -- requirements
Module: pipelined_prenormalizer

---
 rtl/pipelined_prenormalizer.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/pipelined_prenormalizer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipelined_prenormalizer                                      |
// | Description : Two-stage valid/ready FMA pre-normalizer: computes the addend |
// |               alignment shift, aligns A's mantissa, derives sticky and     |
// |               selects exponent/sign/Wallace terms. Optional zero-operand   |
// |               bypass compiled in with PRENORM_ZERO_BYPASS_EN.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipelined_prenormalizer #(
    parameter int PARM_EXP  = 8,
    parameter int PARM_MANT = 23,
    parameter int PARM_BIAS = 127,
    parameter int TAG_W     = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic                       flush_i,
    input  logic                       A_sign_i,
    input  logic                       B_sign_i,
    input  logic                       C_sign_i,
    input  logic                       Sub_Sign_i,
    input  logic                       sign_change_i,
    input  logic [PARM_EXP-1:0]        A_Exp_i,
    input  logic [PARM_EXP-1:0]        B_Exp_i,
    input  logic [PARM_EXP-1:0]        C_Exp_i,
    input  logic [PARM_MANT:0]         A_Mant_i,
    input  logic [2*PARM_MANT+2:0]     Wallace_sum_i,
    input  logic [2*PARM_MANT+2:0]     Wallace_carry_i,
    input  logic [TAG_W-1:0]           tag_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [3*PARM_MANT+5:0]     A_Mant_aligned_o,
    output logic [PARM_EXP+1:0]        Exp_aligned_o,
    output logic [PARM_EXP+1:0]        Exp_mv_neg_o,
    output logic                       Sign_aligned_o,
    output logic                       Exp_mv_sign_o,
    output logic                       Mv_halt_o,
    output logic                       Mant_sticky_sht_out_o,
    output logic [2*PARM_MANT+2:0]     Wallace_sum_aligned_o,
    output logic [2*PARM_MANT+2:0]     Wallace_carry_aligned_o,
    output logic [TAG_W-1:0]           tag_o
);

    localparam int c_EXP_W   = PARM_EXP + 2;
    localparam int c_SIG_W   = PARM_MANT + 1;
    localparam int c_WAL_W   = 2 * PARM_MANT + 3;
    localparam int c_ALN_W   = 3 * PARM_MANT + 6;
    localparam int c_KEPT_W  = 3 * PARM_MANT + 5;
    localparam int c_SHF_W   = c_KEPT_W + c_SIG_W;
    localparam int c_LSH     = 2 * PARM_MANT + 4;

    localparam logic [c_EXP_W-1:0] c_D_X    = c_EXP_W'(PARM_MANT + 4);
    localparam logic [c_EXP_W-1:0] c_BIAS_X = c_EXP_W'(PARM_BIAS);
    localparam logic [c_EXP_W-1:0] c_HALT_X = c_EXP_W'(3 * PARM_MANT + 4);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_s1_valid;
    logic r_s2_valid;
    logic w_s2_free;
    logic w_s1_adv;
    logic w_accept;

    assign w_s2_free   = ~r_s2_valid | out_ready_i;
    assign w_s1_adv    = r_s1_valid & w_s2_free;
    assign in_ready_o  = ~r_s1_valid | w_s1_adv;
    assign w_accept    = in_valid_i & in_ready_o & ~flush_i;
    assign out_valid_o = r_s2_valid;

    // ------------------------------------------------------------------
    // Stage 1 combinational: shift amount, its sign and the halt flag
    // ------------------------------------------------------------------
    logic [c_EXP_W-1:0] w_mv;
    logic               w_mv_sign_raw;
    logic               w_halt_raw;
    logic               w_mv_sign;
    logic               w_halt;

    assign w_mv = c_D_X - c_EXP_W'(A_Exp_i) + c_EXP_W'(B_Exp_i)
                + c_EXP_W'(C_Exp_i) - c_BIAS_X;
    assign w_mv_sign_raw = w_mv[c_EXP_W-1];
    assign w_halt_raw    = ~w_mv_sign_raw & (w_mv > c_HALT_X);

`ifdef PRENORM_ZERO_BYPASS_EN
    // A zero addend always takes the product path with nothing shifted out.
    logic w_a_zero;
    assign w_a_zero  = (A_Mant_i == '0);
    assign w_mv_sign = w_mv_sign_raw & ~w_a_zero;
    assign w_halt    = w_halt_raw & ~w_a_zero;
`else
    assign w_mv_sign = w_mv_sign_raw;
    assign w_halt    = w_halt_raw;
`endif

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic               r_s1_a_sign;
    logic               r_s1_b_sign;
    logic               r_s1_c_sign;
    logic               r_s1_sub;
    logic               r_s1_sign_change;
    logic [PARM_EXP-1:0] r_s1_a_exp;
    logic [PARM_EXP-1:0] r_s1_b_exp;
    logic [PARM_EXP-1:0] r_s1_c_exp;
    logic [c_SIG_W-1:0] r_s1_a_mant;
    logic [c_WAL_W-1:0] r_s1_wsum;
    logic [c_WAL_W-1:0] r_s1_wcarry;
    logic [TAG_W-1:0]   r_s1_tag;
    logic [c_EXP_W-1:0] r_s1_mv;
    logic               r_s1_mv_sign;
    logic               r_s1_halt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid       <= 1'b0;
            r_s1_a_sign      <= 1'b0;
            r_s1_b_sign      <= 1'b0;
            r_s1_c_sign      <= 1'b0;
            r_s1_sub         <= 1'b0;
            r_s1_sign_change <= 1'b0;
            r_s1_a_exp       <= '0;
            r_s1_b_exp       <= '0;
            r_s1_c_exp       <= '0;
            r_s1_a_mant      <= '0;
            r_s1_wsum        <= '0;
            r_s1_wcarry      <= '0;
            r_s1_tag         <= '0;
            r_s1_mv          <= '0;
            r_s1_mv_sign     <= 1'b0;
            r_s1_halt        <= 1'b0;
        end else begin
            if (flush_i) begin
                r_s1_valid <= 1'b0;
            end else if (in_ready_o) begin
                r_s1_valid <= in_valid_i;
            end
            if (w_accept) begin
                r_s1_a_sign      <= A_sign_i;
                r_s1_b_sign      <= B_sign_i;
                r_s1_c_sign      <= C_sign_i;
                r_s1_sub         <= Sub_Sign_i;
                r_s1_sign_change <= sign_change_i;
                r_s1_a_exp       <= A_Exp_i;
                r_s1_b_exp       <= B_Exp_i;
                r_s1_c_exp       <= C_Exp_i;
                r_s1_a_mant      <= A_Mant_i;
                r_s1_wsum        <= Wallace_sum_i;
                r_s1_wcarry      <= Wallace_carry_i;
                r_s1_tag         <= tag_i;
                r_s1_mv          <= w_mv;
                r_s1_mv_sign     <= w_mv_sign;
                r_s1_halt        <= w_halt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: alignment shift, sticky and path selection
    // ------------------------------------------------------------------
    logic [c_SHF_W-1:0]  w_shifted;
    logic [c_KEPT_W-1:0] w_kept;
    logic [c_SIG_W-1:0]  w_dropped;
    logic [c_SIG_W-1:0]  w_sticky_src;
    logic [c_SIG_W-1:0]  w_sticky_val;
    logic                w_sticky;
    logic [c_ALN_W-1:0]  w_mant_aln;
    logic [c_EXP_W-1:0]  w_exp_aln;
    logic                w_sign_aln;
    logic [c_WAL_W-1:0]  w_wsum_aln;
    logic [c_WAL_W-1:0]  w_wcarry_aln;

    assign w_shifted = {r_s1_a_mant, {c_KEPT_W{1'b0}}} >> r_s1_mv;
    assign w_kept    = w_shifted[c_SHF_W-1:c_SIG_W];
    assign w_dropped = w_shifted[c_SIG_W-1:0];

    always_comb begin
        w_sticky_src = '0;
        w_mant_aln   = '0;
        w_exp_aln    = '0;
        w_sign_aln   = 1'b0;
        w_wsum_aln   = '0;
        w_wcarry_aln = '0;
        if (r_s1_mv_sign) begin
            // Addend dominates: park it left of the product, no bits lost.
            w_mant_aln = {1'b0, r_s1_a_mant, {c_LSH{1'b0}}};
            w_exp_aln  = c_EXP_W'(r_s1_a_exp);
            w_sign_aln = r_s1_a_sign;
        end else begin
            w_exp_aln    = c_EXP_W'(r_s1_b_exp) + c_EXP_W'(r_s1_c_exp)
                         - c_BIAS_X + c_D_X;
            w_sign_aln   = r_s1_b_sign ^ r_s1_c_sign;
            w_wsum_aln   = r_s1_wsum;
            w_wcarry_aln = r_s1_wcarry;
            if (r_s1_halt) begin
                w_sticky_src = r_s1_a_mant;
            end else begin
                w_mant_aln   = {r_s1_sub, ~w_kept};
                w_sticky_src = w_dropped;
            end
        end
    end

    // Effective subtraction sees the negated bits; nonzero-ness is preserved.
    assign w_sticky_val = (r_s1_sub & ~r_s1_sign_change)
                        ? (~w_sticky_src + c_SIG_W'(1)) : w_sticky_src;
    assign w_sticky     = |w_sticky_val;

    // ------------------------------------------------------------------
    // Stage 2 registers (module outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s2_valid              <= 1'b0;
            A_Mant_aligned_o        <= '0;
            Exp_aligned_o           <= '0;
            Exp_mv_neg_o            <= '0;
            Sign_aligned_o          <= 1'b0;
            Exp_mv_sign_o           <= 1'b0;
            Mv_halt_o               <= 1'b0;
            Mant_sticky_sht_out_o   <= 1'b0;
            Wallace_sum_aligned_o   <= '0;
            Wallace_carry_aligned_o <= '0;
            tag_o                   <= '0;
        end else begin
            if (flush_i) begin
                r_s2_valid <= 1'b0;
            end else if (w_s2_free) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s1_adv && !flush_i) begin
                A_Mant_aligned_o        <= w_mant_aln;
                Exp_aligned_o           <= w_exp_aln;
                Exp_mv_neg_o            <= -r_s1_mv;
                Sign_aligned_o          <= w_sign_aln;
                Exp_mv_sign_o           <= r_s1_mv_sign;
                Mv_halt_o               <= r_s1_halt;
                Mant_sticky_sht_out_o   <= w_sticky;
                Wallace_sum_aligned_o   <= w_wsum_aln;
                Wallace_carry_aligned_o <= w_wcarry_aln;
                tag_o                   <= r_s1_tag;
            end
        end
    end

endmodule
`default_nettype wire
